seq_pattern_detector: RTL and testbench

//   Parametrised serial bit-pattern detector, successor to the fixed "11" Mealy detector.

---
 rtl/seq_pattern_detector.sv | 91 +++++++++
 tb/tb_seq_pattern_detector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: run-time loadable pattern, Mealy/Moore output
// timing, overlapping or restarting match search, saturating match counter.
module seq_pattern_detector #(
  parameter int unsigned          PATTERN_W    = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_INIT = PATTERN_W'(4'b1101),
  parameter bit                   MEALY        = 1'b1,
  parameter bit                   OVERLAP      = 1'b1,
  parameter int unsigned          CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
  input  logic                 cnt_clr,
  output logic                 out,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat,
  output logic [PATTERN_W-1:0] pattern
);

  localparam int unsigned      FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] cw;
  logic [FILL_W-1:0]    fill;
  logic                 accept;
  logic                 hit;
  logic                 out_reg;

  // Candidate window and hit decode; a load cycle never accepts its bit
  always_comb begin
    accept = in_valid & ~pat_load;
    cw     = {hist[PATTERN_W-2:0], in};
    hit    = accept && (fill >= FILL_HIT) && (cw == pattern);
  end

  // Pattern register, bit history and fill level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= PATTERN_INIT;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pattern <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (accept) begin
      hist <= cw;
      if (hit && !OVERLAP) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Registered hit for the delayed (Moore) output timing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= 1'b0;
    end else if (pat_load) begin
      out_reg <= 1'b0;
    end else begin
      out_reg <= hit;
    end
  end

  // Saturating match counter; a clear coinciding with a hit leaves one match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= hit ? CNT_ONE : '0;
    end else if (hit && !cnt_sat) begin
      match_cnt <= match_cnt + CNT_ONE;
    end
  end

  // Output selection; reset forces the match indication low immediately
  always_comb begin
    cnt_sat = (match_cnt == CNT_MAX);
    out     = MEALY ? (hit & reset) : out_reg;
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: four configurations share one stimulus
// stream and are compared against a bit-list reference model.
module tb_seq_pattern_detector;

  localparam int unsigned NI = 4;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_bit;
  logic pat_load;
  logic [3:0] pat_in;
  logic cnt_clr;

  logic [NI-1:0] out_v;
  logic [NI-1:0] sat_v;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic [3:0] pat0, pat1, pat2, pat3;

  always #5 clk = ~clk;

  // 0: defaults  1: non-overlapping  2: Moore timing  3: 2-bit counter
  seq_pattern_detector u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_v[0]), .match_cnt(cnt0),
    .cnt_sat(sat_v[0]), .pattern(pat0));
  seq_pattern_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_v[1]), .match_cnt(cnt1),
    .cnt_sat(sat_v[1]), .pattern(pat1));
  seq_pattern_detector #(.MEALY(1'b0)) u_moore (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_v[2]), .match_cnt(cnt2),
    .cnt_sat(sat_v[2]), .pattern(pat2));
  seq_pattern_detector #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .out(out_v[3]), .match_cnt(cnt3),
    .cnt_sat(sat_v[3]), .pattern(pat3));

  // Reference model state
  bit       c_mealy [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit       c_ovl   [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int       c_max   [NI] = '{255, 255, 255, 3};
  logic [3:0] m_pat;
  bit       m_stream[$];
  int       m_since [NI];
  int       m_cnt   [NI];
  bit       m_prev  [NI];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [NI-1:0] last_out;

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic logic [3:0] get_pat(input int k);
    case (k)
      0:       return pat0;
      1:       return pat1;
      2:       return pat2;
      default: return pat3;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 4'b1101;
    m_stream.delete();
    for (int k = 0; k < NI; k++) begin
      m_since[k] = 0;
      m_cnt[k]   = 0;
      m_prev[k]  = 1'b0;
    end
  endtask

  // Assert reset away from the clock edge and check the immediate effect
  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0; in_bit = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (out_v[k] !== 1'b0) begin
        errors++; $display("FAIL rst_out k=%0d got=%0b exp=0", k, out_v[k]);
      end
      checks++;
      if (get_cnt(k) != 0) begin
        errors++; $display("FAIL rst_cnt k=%0d got=%0d exp=0", k, get_cnt(k));
      end
      checks++;
      if (get_pat(k) !== 4'b1101) begin
        errors++; $display("FAIL rst_pattern k=%0d got=%b exp=1101", k, get_pat(k));
      end
    end
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // One clock of stimulus, checked against the model before the edge
  task automatic step(input bit v, input bit b, input bit ld, input logic [3:0] pin,
                      input bit clr);
    bit h [NI];
    int w;
    bit e_out;
    @(negedge clk);
    in_valid = v; in_bit = b; pat_load = ld; pat_in = pin; cnt_clr = clr;
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      h[k] = 1'b0;
      if (v && !ld && m_since[k] >= 3) begin
        w = 0;
        for (int i = 0; i < 3; i++) w = (w << 1) | int'(m_stream[m_stream.size() - 3 + i]);
        w = (w << 1) | int'(b);
        h[k] = (w == int'(m_pat));
      end
      e_out = c_mealy[k] ? h[k] : m_prev[k];
      checks++;
      if (out_v[k] !== e_out) begin
        errors++; $display("FAIL out k=%0d cyc=%0d got=%0b exp=%0b", k, cyc, out_v[k], e_out);
      end
      checks++;
      if (get_cnt(k) != m_cnt[k]) begin
        errors++;
        $display("FAIL match_cnt k=%0d cyc=%0d got=%0d exp=%0d", k, cyc, get_cnt(k), m_cnt[k]);
      end
      checks++;
      if (sat_v[k] !== (m_cnt[k] == c_max[k])) begin
        errors++; $display("FAIL cnt_sat k=%0d cyc=%0d got=%0b exp=%0b", k, cyc, sat_v[k],
                           m_cnt[k] == c_max[k]);
      end
      checks++;
      if (get_pat(k) !== m_pat) begin
        errors++; $display("FAIL pattern k=%0d cyc=%0d got=%b exp=%b", k, cyc, get_pat(k), m_pat);
      end
      last_out[k] = out_v[k];
    end
    // model update for the coming edge
    for (int k = 0; k < NI; k++) begin
      if (clr) m_cnt[k] = h[k] ? 1 : 0;
      else if (h[k] && m_cnt[k] < c_max[k]) m_cnt[k]++;
      if (ld) m_since[k] = 0;
      else if (v) m_since[k] = (h[k] && !c_ovl[k]) ? 0 : m_since[k] + 1;
      m_prev[k] = h[k];
    end
    if (ld) begin
      m_pat = pin;
      m_stream.delete();
    end else if (v) begin
      m_stream.push_back(b);
      if (m_stream.size() > 8) void'(m_stream.pop_front());
    end
  endtask

  task automatic acc(input bit b);
    step(1'b1, b, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    pulse_reset();
    // first accepted bits after reset cannot hit
    acc(1'b1);
    checks++;
    if (last_out !== '0) begin
      errors++; $display("FAIL post_reset_out got=%b exp=0000", last_out);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] s0, s1, s2;
    logic [3:0] t1;
    bit bits [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pulse_reset();
    s0 = '0; s1 = '0; s2 = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) acc(bits[i]); else idle();
      s0 = {s0[6:0], last_out[0]};
      s1 = {s1[6:0], last_out[1]};
      s2 = {s2[6:0], last_out[2]};
    end
    checks++;
    if (s0 !== 8'b00010010) begin errors++; $display("FAIL t1_mealy_seq got=%b exp=00010010", s0); end
    checks++;
    if (s1 !== 8'b00010000) begin errors++; $display("FAIL t2_novl_seq got=%b exp=00010000", s1); end
    checks++;
    if (s2 !== 8'b00001001) begin errors++; $display("FAIL t3_moore_seq got=%b exp=00001001", s2); end
    checks++;
    if (cnt0 !== 8'd2 || cnt2 !== 8'd2) begin
      errors++; $display("FAIL t1_cnt got=%0d/%0d exp=2/2", cnt0, cnt2);
    end
    checks++;
    if (cnt1 !== 8'd1) begin errors++; $display("FAIL t2_cnt got=%0d exp=1", cnt1); end
    // non-overlapping instance needs four fresh bits
    t1 = '0;
    acc(1'b1); t1 = {t1[2:0], last_out[1]};
    acc(1'b1); t1 = {t1[2:0], last_out[1]};
    acc(1'b0); t1 = {t1[2:0], last_out[1]};
    acc(1'b1); t1 = {t1[2:0], last_out[1]};
    checks++;
    if (t1 !== 4'b0001) begin errors++; $display("FAIL t2_refill_seq got=%b exp=0001", t1); end
  endtask

  task automatic test_gap();
    logic [6:0] s0;
    pulse_reset();
    s0 = '0;
    acc(1'b1); s0 = {s0[5:0], last_out[0]};
    acc(1'b1); s0 = {s0[5:0], last_out[0]};
    for (int i = 0; i < 3; i++) begin
      idle(); s0 = {s0[5:0], last_out[0]};
    end
    acc(1'b0); s0 = {s0[5:0], last_out[0]};
    acc(1'b1); s0 = {s0[5:0], last_out[0]};
    checks++;
    if (s0 !== 7'b0000001) begin errors++; $display("FAIL t4_gap_seq got=%b exp=0000001", s0); end
  endtask

  task automatic test_load();
    logic [3:0] s0;
    pulse_reset();
    acc(1'b1); acc(1'b1); acc(1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b0011, 1'b0);
    checks++;
    if (last_out[0] !== 1'b0) begin errors++; $display("FAIL t5_load_cycle_out got=1 exp=0"); end
    s0 = '0;
    acc(1'b0); s0 = {s0[2:0], last_out[0]};
    checks++;
    if (pat0 !== 4'b0011) begin errors++; $display("FAIL t5_pattern got=%b exp=0011", pat0); end
    acc(1'b0); s0 = {s0[2:0], last_out[0]};
    acc(1'b1); s0 = {s0[2:0], last_out[0]};
    acc(1'b1); s0 = {s0[2:0], last_out[0]};
    checks++;
    if (s0 !== 4'b0001) begin errors++; $display("FAIL t5_seq got=%b exp=0001", s0); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    acc(1'b1); acc(1'b1); acc(1'b0); acc(1'b1);
    for (int i = 0; i < 4; i++) begin
      acc(1'b1); acc(1'b0); acc(1'b1);
    end
    @(posedge clk); #1;
    checks++;
    if (cnt3 !== 2'd3 || sat_v[3] !== 1'b1) begin
      errors++; $display("FAIL t6_sat got=%0d/%0b exp=3/1", cnt3, sat_v[3]);
    end
    checks++;
    if (cnt0 !== 8'd5) begin errors++; $display("FAIL t6_cnt8 got=%0d exp=5", cnt0); end
    acc(1'b1); acc(1'b0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (cnt3 !== 2'd1 || cnt0 !== 8'd1) begin
      errors++; $display("FAIL t6_clr_hit got=%0d/%0d exp=1/1", cnt3, cnt0);
    end
    // reset while the completing bit is on the input
    acc(1'b1); acc(1'b1); acc(1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1; pat_load = 1'b0; cnt_clr = 1'b0;
    #1;
    checks++;
    if (out_v[0] !== 1'b1) begin errors++; $display("FAIL t6_prereset_hit got=0 exp=1"); end
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_v !== '0 || cnt0 !== 8'd0 || cnt3 !== 2'd0 || pat0 !== 4'b1101) begin
      errors++; $display("FAIL t6_midreset got out=%b cnt=%0d/%0d pat=%b exp 0000/0/0/1101",
                         out_v, cnt0, cnt3, pat0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    // history restarted: the old window must not complete a match
    acc(1'b1);
    checks++;
    if (last_out !== '0) begin errors++; $display("FAIL t6_fill_cleared got=%b exp=0000", last_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 29) == 0, 4'($urandom), $urandom_range(0, 39) == 0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    pat_in = 4'h0; cnt_clr = 1'b0; last_out = '0;
    model_reset();
    test_reset();
    test_overlap();
    test_gap();
    test_load();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
